// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus between the image source and instr_mem_loader.
// The loader connects through the slave modport; the stream source / memory side uses master.
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 16
) ();
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 16-bit words, writes them from
// address 0 and holds the CPU until the image is in. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module instr_mem_loader #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;
`endif

  localparam logic [15:0] MAX_WORDS = 16'(MEM_DEPTH);

  state_t      state;
  logic [7:0]  hi_byte;
  logic        hi_vld;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        accept;
  logic        begin_load;
  logic [15:0] rx_word;
  logic [15:0] idx_nxt;

  assign accept     = bus.in_valid & bus.in_ready;
  assign begin_load = start & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign rx_word    = {hi_byte, bus.in_data};
  assign idx_nxt    = word_idx + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      hi_byte       <= '0;
      hi_vld        <= 1'b0;
      word_cnt      <= '0;
      word_idx      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      if (begin_load) begin
        // done/err drop together with cpu_hold rising, one cycle after start
        state        <= HDR;
        bus.in_ready <= 1'b1;
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
        hi_vld       <= 1'b0;
        word_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end else begin
        case (state)
          HDR: begin
            if (accept) begin
              if (!hi_vld) begin
                hi_byte <= bus.in_data;
                hi_vld  <= 1'b1;
              end else begin
                hi_vld   <= 1'b0;
                word_cnt <= rx_word;
                if (rx_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= CHK;
`else
                  state        <= DONE;
                  bus.in_ready <= 1'b0;
`endif
                end else if (rx_word > MAX_WORDS) begin
                  state        <= ERR;
                  bus.in_ready <= 1'b0;
                end else begin
                  state <= DATA;
                end
              end
            end
          end
          DATA: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
              csum <= csum ^ bus.in_data;
`endif
              if (!hi_vld) begin
                hi_byte <= bus.in_data;
                hi_vld  <= 1'b1;
              end else begin
                // The final write and the move out of DATA share this edge
                hi_vld        <= 1'b0;
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= ADDR_WIDTH'(word_idx);
                bus.mem_wdata <= WORD_WIDTH'(rx_word);
                word_idx      <= idx_nxt;
                if (idx_nxt == word_cnt) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= CHK;
`else
                  state        <= DONE;
                  bus.in_ready <= 1'b0;
`endif
                end
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHK: begin
            if (accept) begin
              bus.in_ready <= 1'b0;
              state        <= (bus.in_data == csum) ? DONE : ERR;
            end
          end
`endif
          DONE: begin
            // cpu_hold releases a cycle after entering DONE, i.e. after the last write lands
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
          ERR: begin
            err      <= 1'b1;
            cpu_hold <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; covers both builds (LOADER_CHECKSUM_EN defined or not).
module tb_instr_mem_loader;
  localparam int AW    = 32;
  localparam int WW    = 16;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  instr_mem_loader_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  instr_mem_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr[$];
  logic [WW-1:0] wr_data[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    logic rdy;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      tick(gap);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20; i++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) return;
    end
    checks++;
    errors++;
    $error("FAIL byte_timeout observed=%h expected=accepted", b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  xs;
    logic [7:0]  b;
    logic [15:0] words[4];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    words[0] = 16'hDEAD; words[1] = 16'hBEEF; words[2] = 16'h0F1E; words[3] = 16'h7788;

    // reset values
    tick(2);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    tick();
    check("idle_in_ready", bus.in_ready, 0);

    // two-word load
    clear_log();
    pulse_start();
    check("t1_in_ready", bus.in_ready, 1);
    check("t1_hold", cpu_hold, 1);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    check("t1_we0", bus.mem_we, 1);
    check("t1_addr0", bus.mem_addr, 0);
    check("t1_data0", bus.mem_wdata, 16'h1234);
    send_byte(8'hAB); send_byte(8'hCD);
    check("t1_we1", bus.mem_we, 1);
    check("t1_addr1", bus.mem_addr, 1);
    check("t1_data1", bus.mem_wdata, 16'hABCD);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h40);
`endif
    bus.in_valid = 1'b0;
    check("t1_ready_low", bus.in_ready, 0);
    check("t1_done_early", done, 0);
    check("t1_hold_early", cpu_hold, 1);
    tick();
    check("t1_done", done, 1);
    check("t1_hold_rel", cpu_hold, 0);
    check("t1_we_pulse", bus.mem_we, 0);
    check("t1_nwr", wr_addr.size(), 2);
    check("t1_log_d1", wr_data[1], 16'hABCD);

    // empty image
    clear_log();
    pulse_start();
    check("t2_rehold", cpu_hold, 1);
    check("t2_done_clr", done, 0);
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    bus.in_valid = 1'b0;
    check("t2_done_early", done, 0);
    tick();
    check("t2_done", done, 1);
    check("t2_hold", cpu_hold, 0);
    check("t2_nwr", wr_addr.size(), 0);

    // oversize header
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h41);
    bus.in_valid = 1'b0;
    tick();
    check("t3_err", err, 1);
    check("t3_hold", cpu_hold, 1);
    check("t3_ready", bus.in_ready, 0);
    check("t3_done", done, 0);
    tick(2);
    check("t3_nwr", wr_addr.size(), 0);

    // exactly MEM_DEPTH words
    clear_log();
    pulse_start();
    check("t3b_err_clr", err, 0);
    send_byte(8'h00); send_byte(8'h40);
    xs = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'(i);
      send_byte(b);
      send_byte(~b);
      xs = xs ^ b ^ ~b;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(xs);
`endif
    bus.in_valid = 1'b0;
    tick();
    check("t3b_done", done, 1);
    check("t3b_err", err, 0);
    check("t3b_nwr", wr_addr.size(), DEPTH);
    check("t3b_last_addr", wr_addr[DEPTH-1], DEPTH - 1);
    check("t3b_last_data", wr_data[DEPTH-1], 16'h3FC0);

    // four words with random gaps
    clear_log();
    pulse_start();
    send_byte(8'h00, $urandom_range(0, 3));
    send_byte(8'h04, $urandom_range(0, 3));
    xs = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send_byte(words[i][15:8], $urandom_range(0, 3));
      send_byte(words[i][7:0], $urandom_range(0, 3));
      xs = xs ^ words[i][15:8] ^ words[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(xs, $urandom_range(0, 3));
`endif
    bus.in_valid = 1'b0;
    tick();
    check("t4_done", done, 1);
    check("t4_nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (wr_addr.size() > i) begin
        check($sformatf("t4_addr%0d", i), wr_addr[i], i);
        check($sformatf("t4_data%0d", i), wr_data[i], words[i]);
      end
    end

    // asynchronous reset mid-load, then reload from 0
    pulse_start();
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
    bus.in_valid = 1'b0;
    check("t5_we_before", bus.mem_we, 1);
    reset_n = 1'b0;
    #1;
    check("t5_in_ready", bus.in_ready, 0);
    check("t5_mem_we", bus.mem_we, 0);
    check("t5_mem_addr", bus.mem_addr, 0);
    check("t5_mem_wdata", bus.mem_wdata, 0);
    check("t5_hold", cpu_hold, 1);
    check("t5_done", done, 0);
    check("t5_err", err, 0);
    tick();
    reset_n = 1'b1;
    tick();
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h5A); send_byte(8'hA5);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hFF);
`endif
    bus.in_valid = 1'b0;
    tick();
    check("t5_reload_done", done, 1);
    check("t5_reload_nwr", wr_addr.size(), 1);
    check("t5_reload_addr", wr_addr[0], 0);
    check("t5_reload_data", wr_data[0], 16'h5AA5);

`ifdef LOADER_CHECKSUM_EN
    // checksum match and mismatch
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
    bus.in_valid = 1'b0;
    tick();
    check("t6_done", done, 1);
    check("t6_err_ok", err, 0);
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
    bus.in_valid = 1'b0;
    tick();
    check("t6_err", err, 1);
    check("t6_hold", cpu_hold, 1);
    check("t6_done_bad", done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
